// File: rtl/load_pkg.sv
// Shared types and helpers for the load fetch unit.
//   load_funct3_t : RISC-V load funct3 encodings handled by the unit
//   lf_state_t    : sequencer states
//   size_of()     : access size in bytes for a funct3
//   is_legal()    : funct3 is one of LB/LH/LW/LBU/LHU
package load_pkg;

   typedef enum logic [2:0] {
      LB  = 3'd0,
      LH  = 3'd1,
      LW  = 3'd2,
      LBU = 3'd4,
      LHU = 3'd5
   } load_funct3_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD1  = 2'd1,
      RD2  = 2'd2,
      DONE = 2'd3
   } lf_state_t;

   // Illegal encodings fall into the 4-byte bucket; they never reach the bus.
   function automatic logic [2:0] size_of(input logic [2:0] funct3);
      case (funct3[1:0])
         2'd0:    return 3'd1;
         2'd1:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic is_legal(input logic [2:0] funct3);
      case (funct3)
         3'd0, 3'd1, 3'd2, 3'd4, 3'd5: return 1'b1;
         default:                      return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// Byte alignment and sign/zero extension of a load result.
// Ports:
//   data_1  in  32  first fetched word (lower address)
//   data_2  in  32  second fetched word (next word, 0 for single reads)
//   offset  in  2   byte offset of the load inside data_1
//   funct3  in  3   load type
//   result  out 32  aligned, extended load data
module load_align
   import load_pkg::*;
(
   input  logic [31:0] data_1,
   input  logic [31:0] data_2,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [63:0] window;
   logic [31:0] aligned;
   logic [2:0]  idx;

   assign window = {data_2, data_1};

   // aligned byte k comes from window byte offset+k (little-endian)
   always_comb begin
      aligned = '0;
      idx     = '0;
      for (int k = 0; k < 4; k++) begin
         idx = {1'b0, offset} + 3'(k);
         aligned[8*k +: 8] = window[{idx, 3'b000} +: 8];
      end
   end

   always_comb begin
      result = '0;
      case (funct3)
         LB:      result = {{24{aligned[7]}}, aligned[7:0]};
         LBU:     result = {24'd0, aligned[7:0]};
         LH:      result = {{16{aligned[15]}}, aligned[15:0]};
         LHU:     result = {16'd0, aligned[15:0]};
         LW:      result = aligned;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/load_fetch_unit.sv
// Load-side memory sequencer: accepts one load request, performs one or two
// Wishbone-classic word reads, and returns the aligned/extended result.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/ready          request handshake
//   req_addr, req_funct3     byte address and load type
//   wb_cyc/stb/adr           Wishbone master read outputs
//   wb_dat_i/ack/err         Wishbone slave responses
//   rsp_valid/ready          response handshake
//   rsp_data, rsp_err        result data and error flag
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// RD1   | reading the word holding the first byte
// RD2   | reading the following word of a word-crossing load
// DONE  | result presented until the consumer takes it
module load_fetch_unit
   import load_pkg::*;
#(
   parameter int ALLOW_SPLIT = 1,
   parameter int ADDR_W      = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [2:0]        req_funct3,
   output logic              wb_cyc,
   output logic              wb_stb,
   output logic [ADDR_W-1:0] wb_adr,
   input  logic [31:0]       wb_dat_i,
   input  logic              wb_ack,
   input  logic              wb_err,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_data,
   output logic              rsp_err
);

   lf_state_t         state, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        funct3_q;
   logic              split_q;
   logic              err_q;
   logic [31:0]       data_1, data_2;
   logic [31:0]       aligned;

   logic [3:0]        req_end;
   logic              req_split;
   logic              req_bad;
   logic [ADDR_W-3:0] word_q;
   logic [ADDR_W-3:0] word_nxt;

   assign req_end   = {2'b00, req_addr[1:0]} + {1'b0, size_of(req_funct3)};
   assign req_split = (req_end > 4'd4);
   assign req_bad   = !is_legal(req_funct3) || (req_split && (ALLOW_SPLIT == 0));

   // second word address wraps naturally at the top of the address space
   assign word_q   = addr_q[ADDR_W-1:2];
   assign word_nxt = word_q + {{(ADDR_W-3){1'b0}}, 1'b1};

   load_align u_align (
      .data_1 (data_1),
      .data_2 (data_2),
      .offset (addr_q[1:0]),
      .funct3 (funct3_q),
      .result (aligned)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (req_valid) state_nxt = req_bad ? DONE : RD1;
         RD1: begin
            if (wb_err)      state_nxt = DONE;
            else if (wb_ack) state_nxt = split_q ? RD2 : DONE;
         end
         RD2:  if (wb_err || wb_ack) state_nxt = DONE;
         DONE: if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q   <= '0;
         funct3_q <= '0;
         split_q  <= 1'b0;
         err_q    <= 1'b0;
         data_1   <= '0;
         data_2   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q   <= req_addr;
                  funct3_q <= req_funct3;
                  split_q  <= req_split;
                  err_q    <= req_bad;
               end
            end
            RD1: begin
               if (wb_err) begin
                  err_q <= 1'b1;
               end else if (wb_ack) begin
                  data_1 <= wb_dat_i;
                  if (!split_q) data_2 <= '0;
               end
            end
            RD2: begin
               if (wb_err)      err_q  <= 1'b1;
               else if (wb_ack) data_2 <= wb_dat_i;
            end
            default: ;
         endcase
      end
   end

   // outputs decode from state only, so reset drops the bus asynchronously
   always_comb begin
      req_ready = 1'b0;
      wb_cyc    = 1'b0;
      wb_stb    = 1'b0;
      wb_adr    = '0;
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      rsp_data  = '0;
      case (state)
         IDLE: req_ready = 1'b1;
         RD1: begin
            wb_cyc = 1'b1;
            wb_stb = 1'b1;
            wb_adr = {word_q, 2'b00};
         end
         RD2: begin
            wb_cyc = 1'b1;
            wb_stb = 1'b1;
            wb_adr = {word_nxt, 2'b00};
         end
         DONE: begin
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            rsp_data  = err_q ? 32'd0 : aligned;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_load_fetch_unit.sv
// Scoreboard bench for load_fetch_unit: a driver pushes expected responses,
// a monitor pops and compares on every response handshake.
module tb_load_fetch_unit;
   import load_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   logic        req_valid, req_ready;
   logic [31:0] req_addr;
   logic [2:0]  req_funct3;
   logic        wb_cyc, wb_stb, wb_ack, wb_err;
   logic [31:0] wb_adr, wb_dat_i;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_data;

   logic        req_valid_ns, req_ready_ns;
   logic        wb_cyc_ns, wb_stb_ns;
   logic [31:0] wb_adr_ns;
   logic [31:0] wb_dat_i_ns;
   logic        wb_ack_ns, wb_err_ns;
   logic        rsp_valid_ns, rsp_ready_ns, rsp_err_ns;
   logic [31:0] rsp_data_ns;

   assign wb_dat_i_ns = 32'd0;
   assign wb_ack_ns   = 1'b0;
   assign wb_err_ns   = 1'b0;

   load_fetch_unit #(.ALLOW_SPLIT(1), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_funct3(req_funct3),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_adr(wb_adr),
      .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .wb_err(wb_err),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err)
   );

   load_fetch_unit #(.ALLOW_SPLIT(0), .ADDR_W(32)) dut_ns (
      .clk(clk), .rst(rst),
      .req_valid(req_valid_ns), .req_ready(req_ready_ns),
      .req_addr(req_addr), .req_funct3(req_funct3),
      .wb_cyc(wb_cyc_ns), .wb_stb(wb_stb_ns), .wb_adr(wb_adr_ns),
      .wb_dat_i(wb_dat_i_ns), .wb_ack(wb_ack_ns), .wb_err(wb_err_ns),
      .rsp_valid(rsp_valid_ns), .rsp_ready(rsp_ready_ns),
      .rsp_data(rsp_data_ns), .rsp_err(rsp_err_ns)
   );

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          nreads;
      logic [31:0] adr1;
      logic [31:0] adr2;
      int          ncyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t exp_ns_q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %08h, required %08h", name, act, req);
      end
   endtask

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (a == 32'h100)      return 32'h12345678;
      else if (a == 32'h104) return 32'habcdefee;
      else                   return 32'h5a5a0000 ^ a;
   endfunction

   // zero-wait slave: acks the cycle after it sees stb
   logic        inject_err;
   logic [31:0] err_adr;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_ack   <= 1'b0;
         wb_err   <= 1'b0;
         wb_dat_i <= 32'd0;
      end else begin
         wb_ack <= 1'b0;
         wb_err <= 1'b0;
         if (wb_stb && !wb_ack && !wb_err) begin
            if (inject_err && wb_adr == err_adr) begin
               wb_err <= 1'b1;
            end else begin
               wb_ack   <= 1'b1;
               wb_dat_i <= mem_read(wb_adr);
            end
         end
      end
   end

   // monitor for the split-capable unit
   int          nreads;
   int          ncyc;
   logic        cyc_prev;
   logic [31:0] adrs [2];
   exp_t        e;
   always @(negedge clk) begin
      if (rst) begin
         nreads   = 0;
         ncyc     = 0;
         cyc_prev = 1'b0;
      end else begin
         if (wb_cyc !== wb_stb) check("cyc_eq_stb", {31'd0, wb_cyc}, {31'd0, wb_stb});
         if (wb_cyc && !cyc_prev) ncyc++;
         cyc_prev = wb_cyc;
         if (wb_stb && (wb_ack || wb_err)) begin
            if (nreads < 2) adrs[nreads] = wb_adr;
            nreads++;
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_rsp: got data %08h err %0d, required no response", rsp_data, rsp_err);
            end else begin
               e = exp_q.pop_front();
               check("rsp_data", rsp_data, e.data);
               check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
               check("bus_reads", nreads, e.nreads);
               if (e.nreads >= 1) check("adr1", adrs[0], e.adr1);
               if (e.nreads >= 2) check("adr2", adrs[1], e.adr2);
               check("cyc_bursts", ncyc, e.ncyc);
            end
            nreads = 0;
            ncyc   = 0;
         end
      end
   end

   // monitor for the no-split unit; its bus must stay silent
   int   ns_bus;
   exp_t e_ns;
   always @(negedge clk) begin
      if (rst) begin
         ns_bus = 0;
      end else begin
         if (wb_cyc_ns || wb_stb_ns) ns_bus++;
         if (rsp_valid_ns && rsp_ready_ns) begin
            if (exp_ns_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_rsp_ns: got data %08h err %0d, required no response", rsp_data_ns, rsp_err_ns);
            end else begin
               e_ns = exp_ns_q.pop_front();
               check("ns_rsp_data", rsp_data_ns, e_ns.data);
               check("ns_rsp_err", {31'd0, rsp_err_ns}, {31'd0, e_ns.err});
               check("ns_bus_cycles", ns_bus, 0);
            end
            ns_bus = 0;
         end
      end
   end

   task automatic push_exp(input logic ns, input logic [31:0] d, input logic er, input int nr,
                           input logic [31:0] a1, input logic [31:0] a2, input int nc);
      exp_t x;
      x.data = d; x.err = er; x.nreads = nr; x.adr1 = a1; x.adr2 = a2; x.ncyc = nc;
      if (ns) exp_ns_q.push_back(x);
      else    exp_q.push_back(x);
   endtask

   task automatic drive_req(input logic ns, input logic [31:0] a, input logic [2:0] f3);
      int t = 0;
      @(negedge clk);
      while (!(ns ? req_ready_ns : req_ready) && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         tests++;
         fails++;
         $display("FAIL req_ready_timeout: got 0, required 1");
      end
      req_addr   = a;
      req_funct3 = f3;
      if (ns) req_valid_ns = 1'b1;
      else    req_valid    = 1'b1;
      @(negedge clk);
      req_valid    = 1'b0;
      req_valid_ns = 1'b0;
   endtask

   task automatic wait_rsp(input logic ns);
      int t = 0;
      while ((ns ? exp_ns_q.size() : exp_q.size()) != 0 && t < 60) begin
         @(negedge clk);
         t++;
      end
      if (t >= 60) begin
         tests++;
         fails++;
         $display("FAIL rsp_timeout: got %0d pending, required 0", ns ? exp_ns_q.size() : exp_q.size());
         exp_q.delete();
         exp_ns_q.delete();
      end
   endtask

   task automatic issue(input logic ns, input logic [31:0] a, input logic [2:0] f3,
                        input logic [31:0] d, input logic er, input int nr,
                        input logic [31:0] a1, input logic [31:0] a2, input int nc);
      push_exp(ns, d, er, nr, a1, a2, nc);
      drive_req(ns, a, f3);
      wait_rsp(ns);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      rst          = 1'b1;
      req_valid    = 1'b0;
      req_valid_ns = 1'b0;
      req_addr     = 32'd0;
      req_funct3   = 3'd0;
      rsp_ready    = 1'b1;
      rsp_ready_ns = 1'b1;
      inject_err   = 1'b0;
      err_adr      = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_wb_cyc", {31'd0, wb_cyc}, 32'd0);
      check("rst_wb_stb", {31'd0, wb_stb}, 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      rst = 1'b0;

      //     ns  addr           funct3  data           err   nr adr1           adr2           cyc
      issue(0, 32'h100,      3'd2, 32'h12345678, 1'b0, 1, 32'h100,      32'h0,         1);
      issue(0, 32'h103,      3'd0, 32'h00000012, 1'b0, 1, 32'h100,      32'h0,         1);
      issue(0, 32'h107,      3'd4, 32'h000000ab, 1'b0, 1, 32'h104,      32'h0,         1);
      issue(0, 32'h104,      3'd0, 32'hffffffee, 1'b0, 1, 32'h104,      32'h0,         1);
      issue(0, 32'h102,      3'd1, 32'h00001234, 1'b0, 1, 32'h100,      32'h0,         1);
      issue(0, 32'h103,      3'd1, 32'hffffee12, 1'b0, 2, 32'h100,      32'h104,       1);
      issue(0, 32'h103,      3'd5, 32'h0000ee12, 1'b0, 2, 32'h100,      32'h104,       1);
      issue(0, 32'h102,      3'd2, 32'hefee1234, 1'b0, 2, 32'h100,      32'h104,       1);
      issue(0, 32'h100,      3'd3, 32'h00000000, 1'b1, 0, 32'h0,        32'h0,         0);
      issue(0, 32'h100,      3'd7, 32'h00000000, 1'b1, 0, 32'h0,        32'h0,         0);
      issue(0, 32'hfffffffe, 3'd2, 32'h0000a5a5, 1'b0, 2, 32'hfffffffc, 32'h00000000, 1);

      issue(1, 32'h102,      3'd2, 32'h00000000, 1'b1, 0, 32'h0,        32'h0,         0);
      issue(1, 32'h103,      3'd1, 32'h00000000, 1'b1, 0, 32'h0,        32'h0,         0);

      inject_err = 1'b1;
      err_adr    = 32'h104;
      issue(0, 32'h102,      3'd2, 32'h00000000, 1'b1, 2, 32'h100,      32'h104,       1);
      inject_err = 1'b0;
      @(negedge clk);
      check("idle_after_err", {31'd0, req_ready}, 32'd1);

      // backpressure: response must hold steady while rsp_ready is low
      rsp_ready = 1'b0;
      push_exp(0, 32'h12345678, 1'b0, 1, 32'h100, 32'h0, 1);
      drive_req(0, 32'h100, 3'd2);
      t = 0;
      while (!rsp_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      for (int i = 0; i < 5; i++) begin
         check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         check("bp_rsp_data", rsp_data, 32'h12345678);
         check("bp_req_ready", {31'd0, req_ready}, 32'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      wait_rsp(0);

      // reset during the second read of a split load
      drive_req(0, 32'h102, 3'd2);
      t = 0;
      while (!(wb_stb && wb_adr == 32'h104) && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("reached_rd2", {31'd0, (wb_stb && wb_adr == 32'h104)}, 32'd1);
      rst = 1'b1;
      #1;
      check("rst_async_cyc", {31'd0, wb_cyc}, 32'd0);
      check("rst_async_stb", {31'd0, wb_stb}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
      repeat (6) begin
         @(negedge clk);
         check("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      end

      issue(0, 32'h106,      3'd1, 32'hffffabcd, 1'b0, 1, 32'h104,      32'h0,         1);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
